// File: rtl/instr_word_queue.sv
// instr_word_queue -- decoded-instruction queue between decode and execute.
//
// Packs the decoded fields of one instruction into a single instruction word
// and buffers up to DEPTH of them behind valid/ready handshakes. A flush
// empties the queue (branch redirect). While no valid entry is presented the
// output word is all zeros, so execute may latch it unqualified as a bubble.
//
// Instruction word layout, MSB first:
//   {ctrl[CTRL_W-1:0], immediate[31:0], rs1[4:0], rs2[4:0], rd[4:0],
//    pc[31:0], instr_data[31:0]}
//
// Optional feature macro: INSTR_QUEUE_BYPASS_EN
//   defined   -> when empty, a presented instruction appears on instr_word in
//                the same cycle; if execute takes it, it is never stored.
//   undefined -> minimum latency of one cycle, deq_valid depends on count only.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   flush           synchronous clear of all entries, dominates handshakes
//   enq_valid/ready decode-side handshake (ready is register-derived)
//   ctrl, immediate, rs1, rs2, rd, pc, instr_data   decoded fields in
//   deq_valid/ready execute-side handshake
//   instr_word      head entry, or all-zero bubble when deq_valid=0
//   count           current occupancy
module instr_word_queue #(
  parameter int DEPTH = 4,
  parameter int CTRL_W = 16,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int IW_W = CTRL_W + 32 + 15 + 32 + 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [CTRL_W-1:0] ctrl,
  input  logic [31:0]       immediate,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [4:0]        rd,
  input  logic [31:0]       pc,
  input  logic [31:0]       instr_data,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [IW_W-1:0]   instr_word,
  output logic [CW-1:0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ZERO = PW'(0);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [IW_W-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [IW_W-1:0] packed_in;
  logic            bypass;
  logic            bypass_take;
  logic            enq_fire;
  logic            deq_fire;
  logic            wr_en;
  logic            rd_en;

  assign packed_in = {ctrl, immediate, rs1, rs2, rd, pc, instr_data};

  // Depends only on the occupancy register, never on deq_ready, so a full
  // queue refuses an enqueue even when a dequeue fires in the same cycle.
  assign enq_ready = (count < CNT_FULL);

`ifdef INSTR_QUEUE_BYPASS_EN
  assign bypass = (count == CNT_ZERO) && enq_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign deq_valid = (count != CNT_ZERO) || bypass;

  // A bypassed word taken by execute in the same cycle is neither stored nor
  // counted; both pointers stay put.
  assign bypass_take = bypass && deq_ready;
  assign enq_fire    = enq_valid && enq_ready && !flush;
  assign deq_fire    = deq_valid && deq_ready && !flush;
  assign wr_en       = enq_fire && !bypass_take;
  assign rd_en       = deq_fire && !bypass_take;

  // Output select: bypassed input, stored head, or the all-zero bubble.
  always_comb begin
    instr_word = '0;
    if (bypass) begin
      instr_word = packed_in;
    end else if (deq_valid) begin
      instr_word = mem[rd_ptr];
    end else begin
      instr_word = '0;
    end
  end

  // Pointer and occupancy registers; flush returns them to the empty state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= PTR_ZERO;
      rd_ptr <= PTR_ZERO;
      count  <= CNT_ZERO;
    end else if (flush) begin
      wr_ptr <= PTR_ZERO;
      rd_ptr <= PTR_ZERO;
      count  <= CNT_ZERO;
    end else begin
      // Pointers are log2(DEPTH) bits wide and DEPTH is a power of two,
      // so the increment wraps from DEPTH-1 to 0 on its own.
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end else begin
        wr_ptr <= wr_ptr;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end else begin
        rd_ptr <= rd_ptr;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= packed_in;
    end
  end

endmodule

// File: tb/tb_instr_word_queue.sv
// Testbench for instr_word_queue (DEPTH=4, CTRL_W=16).
// A driver issues directed then random stimulus after each rising edge and,
// from a simple occupancy model, publishes the expected count/ready/valid and
// pushes every accepted instruction word onto an expected-word queue. A
// separate monitor on the falling edge compares the handshake outputs, checks
// the bubble word, and pops/compares the head on every dequeue.
module tb_instr_word_queue;

  localparam int DEPTH  = 4;
  localparam int CTRL_W = 16;
  localparam int CW     = 3;
  localparam int IW_W   = CTRL_W + 32 + 15 + 32 + 32;

`ifdef INSTR_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              enq_valid = 1'b0;
  logic              enq_ready;
  logic [CTRL_W-1:0] ctrl = '0;
  logic [31:0]       immediate = '0;
  logic [4:0]        rs1 = '0;
  logic [4:0]        rs2 = '0;
  logic [4:0]        rd = '0;
  logic [31:0]       pc = '0;
  logic [31:0]       instr_data = '0;
  logic              deq_valid;
  logic              deq_ready = 1'b0;
  logic [IW_W-1:0]   instr_word;
  logic [CW-1:0]     count;

  always #5 clk = ~clk;

  instr_word_queue #(.DEPTH(DEPTH), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .ctrl(ctrl), .immediate(immediate), .rs1(rs1), .rs2(rs2), .rd(rd),
    .pc(pc), .instr_data(instr_data),
    .deq_valid(deq_valid), .deq_ready(deq_ready),
    .instr_word(instr_word), .count(count)
  );

  int checks = 0;
  int failures = 0;

  logic [IW_W-1:0] exp_q[$];
  int model_count = 0;
  int exp_count = 0;
  bit exp_enq_ready = 1'b1;
  bit exp_deq_valid = 1'b0;
  bit flush_pending = 1'b0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [IW_W-1:0] got, input logic [IW_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [IW_W-1:0] pack_word(
      input logic [CTRL_W-1:0] c, input logic [31:0] imm,
      input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
      input logic [31:0] p, input logic [31:0] ins);
    return {c, imm, a, b, d, p, ins};
  endfunction

  // One cycle of stimulus plus the reference occupancy model.
  task automatic drive(input bit ev, input bit dr, input bit fl, input logic [31:0] pcv);
    bit byp;
    bit enq_acc;
    bit deq_acc;
    @(posedge clk);
    #1;
    if (flush_pending) exp_q.delete();
    enq_valid  = ev;
    deq_ready  = dr;
    flush      = fl;
    pc         = pcv;
    ctrl       = CTRL_W'($urandom);
    immediate  = $urandom;
    rs1        = 5'($urandom);
    rs2        = 5'($urandom);
    rd         = 5'($urandom);
    instr_data = $urandom;
    byp = BYP && (model_count == 0) && ev && !fl;
    exp_count     = model_count;
    exp_enq_ready = (model_count < DEPTH);
    exp_deq_valid = (model_count != 0) || byp;
    enq_acc = ev && exp_enq_ready && !fl;
    deq_acc = exp_deq_valid && dr && !fl;
    if (enq_acc) exp_q.push_back(pack_word(ctrl, immediate, rs1, rs2, rd, pc, instr_data));
    if (fl) model_count = 0;
    else if (!(byp && dr)) model_count = model_count + int'(enq_acc) - int'(deq_acc);
    flush_pending = fl;
  endtask

  // Monitor: compares outputs every cycle and consumes expected words.
  always @(negedge clk) begin
    if (mon_en) begin
      check("count", IW_W'(count), IW_W'(exp_count));
      check("enq_ready", IW_W'(enq_ready), IW_W'(exp_enq_ready));
      check("deq_valid", IW_W'(deq_valid), IW_W'(exp_deq_valid));
      if (!deq_valid) begin
        check("bubble", instr_word, '0);
      end else if (deq_ready && !flush) begin
        if (exp_q.size() == 0) begin
          check("unexpected_deq", IW_W'(1), IW_W'(0));
        end else begin
          check("head_word", instr_word, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);

    // Fill to DEPTH, then a refused fifth enqueue while the head drains.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 32'h100 + 32'(4 * i));
    drive(1'b1, 1'b1, 1'b0, 32'h110);

    // Streaming with constant occupancy; pointers wrap several times.
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b0, 32'h1000 + 32'(4 * i));

    // Flush with entries held and a simultaneous enqueue of 0x200.
    drive(1'b1, 1'b0, 1'b1, 32'h200);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);

    // Enqueue into an empty queue with execute ready.
    drive(1'b1, 1'b1, 1'b0, 32'h300);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);

    // Asynchronous reset mid-cycle with three entries held.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 32'h400 + 32'(4 * i));
    @(posedge clk);
    #1;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    flush     = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("rst_count", IW_W'(count), IW_W'(0));
    check("rst_deq_valid", IW_W'(deq_valid), IW_W'(0));
    check("rst_enq_ready", IW_W'(enq_ready), IW_W'(1));
    check("rst_word", instr_word, '0);
    model_count   = 0;
    exp_count     = 0;
    exp_enq_ready = 1'b1;
    exp_deq_valid = 1'b0;
    flush_pending = 1'b0;
    exp_q.delete();
    @(negedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h500);
    drive(1'b0, 1'b1, 1'b0, 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 10000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 63) == 0, $urandom);
    end
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    check("drained", IW_W'(exp_q.size()), IW_W'(0));
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
